// File: rtl/run_detector_pkg.sv
// Shared types and constants for the multi-channel run-length detector.
package run_detector_pkg;

  // Per-channel detector state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // run count is 0
    RUN  = 2'd1,  // 0 < count < THRESH
    DET  = 2'd2   // count saturated at THRESH
  } state_t;

  // Encoding of the mode input.
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/run_detector_channel.sv
// One channel of the run detector: counts consecutive high samples of w,
// holds DET while w stays high, and reports the edge on which DET is entered.
module run_detector_channel
  import run_detector_pkg::*;
#(
  parameter int THRESH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic w,
  output logic det,
  output logic pulse,
  output logic entry
);

  localparam int CW = $clog2(THRESH + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          last_step;

  // Flag the sample that completes the run, and the resulting entry into DET.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path
    // (here unconditionally) so no latch is inferred.
    last_step = (count == CW'(THRESH - 1));
    entry     = w && !clear && (state != DET) && last_step;
  end

  // Run counter, state and one-cycle pulse flag; clear outranks w.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block ordering.
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      pulse <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      count <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= entry;
      if (!w) begin
        state <= IDLE;
        count <= '0;
      end else if (state == DET || last_step) begin
        state <= DET;
        count <= CW'(THRESH);
      end else begin
        state <= RUN;
        count <= count + CW'(1);
      end
    end
  end

  // DET decode straight from the state register keeps w off any path to out.
  assign det = (state == DET);

endmodule

// File: rtl/run_detector.sv
// Multi-channel run-length detector: one channel FSM per input, a mode mux
// selecting level or pulse output, and a wrapping tally of detection events.
module run_detector
  import run_detector_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int THRESH   = 2,
  parameter int HIT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic                clear,
  input  logic [CHANNELS-1:0] w,
  output logic [CHANNELS-1:0] out,
  output logic [HIT_W-1:0]    hits
);

  logic [CHANNELS-1:0] det;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] entry;
  logic [HIT_W-1:0]    entry_count;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    run_detector_channel #(
      .THRESH(THRESH)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .w    (w[g]),
      .det  (det[g]),
      .pulse(pulse[g]),
      .entry(entry[g])
    );
  end

  // Mode mux: the only combinational path to out, so a mode change is immediate.
  always_comb begin
    out = (mode == MODE_PULSE) ? pulse : det;
  end

  // Popcount of this edge's entry events; the modular sum matches the wrapping tally.
  always_comb begin
    entry_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      entry_count = entry_count + HIT_W'(entry[i]);
    end
  end

  // Detection-event tally, wrapping at 2^HIT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits <= '0;
    end else if (clear) begin
      hits <= '0;
    end else begin
      hits <= hits + entry_count;
    end
  end

endmodule

// File: tb/tb_run_detector.sv
// Bench for run_detector: a THRESH=2 four-channel instance and a THRESH=1
// single-channel instance share clock, reset, mode and clear. A run-length
// model predicts out and hits for both; hand-computed values pin key points.
`timescale 1ns/100ps
module tb_run_detector;

  localparam int TA = 2;  // threshold of the main instance
  localparam int TB = 1;  // threshold of the second instance

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] w = 4'h0;
  logic [3:0] out_a;
  logic [7:0] hits_a;
  logic [0:0] out_b;
  logic [7:0] hits_b;

  int total = 0;
  int bad = 0;

  run_detector #(.CHANNELS(4), .THRESH(TA), .HIT_W(8)) dut_a (
    .clk(clk), .reset(reset), .mode(mode), .clear(clear),
    .w(w), .out(out_a), .hits(hits_a)
  );

  run_detector #(.CHANNELS(1), .THRESH(TB), .HIT_W(8)) dut_b (
    .clk(clk), .reset(reset), .mode(mode), .clear(clear),
    .w(w[0:0]), .out(out_b), .hits(hits_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: run length of consecutive high samples ----------
  // run = number of consecutive high samples, capped at T+1 so that run==T
  // identifies the single cycle right after the T-th high sample.
  int         run_a [4];
  int         run_b;
  logic [7:0] mh_a;
  logic [7:0] mh_b;
  int         nr;
  logic [7:0] acc;

  always @(posedge clk or negedge reset) begin
    if (!reset || clear) begin
      for (int i = 0; i < 4; i++) run_a[i] <= 0;
      run_b <= 0;
      mh_a  <= 8'd0;
      mh_b  <= 8'd0;
    end else begin
      acc = mh_a;
      for (int i = 0; i < 4; i++) begin
        nr = w[i] ? ((run_a[i] <= TA) ? run_a[i] + 1 : run_a[i]) : 0;
        if (w[i] && nr == TA) acc = acc + 8'd1;
        run_a[i] <= nr;
      end
      mh_a <= acc;
      nr = w[0] ? ((run_b <= TB) ? run_b + 1 : run_b) : 0;
      if (w[0] && nr == TB) mh_b <= mh_b + 8'd1;
      run_b <= nr;
    end
  end

  function automatic logic [3:0] exp_out_a();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mode ? (run_a[i] == TA) : (run_a[i] >= TA);
    return r;
  endfunction

  // Cycle-by-cycle comparison, well away from the rising edge.
  always @(negedge clk) begin
    #1;
    check("out_a", 32'(out_a), 32'(exp_out_a()));
    check("hits_a", 32'(hits_a), 32'(mh_a));
    check("out_b", 32'(out_b), 32'(mode ? (run_b == TB) : (run_b >= TB)));
    check("hits_b", 32'(hits_b), 32'(mh_b));
  end

  // ---------------- stimulus ----------------------------------------------
  // Apply inputs at a falling edge; return at the next falling edge, when the
  // outputs reflect the rising edge that sampled them.
  task automatic cyc(input logic [3:0] wv, input logic clr);
    w = wv;
    clear = clr;
    @(negedge clk);
  endtask

  int highs;

  initial begin
    @(negedge clk);
    // Reset held with w toggling.
    for (int i = 0; i < 4; i++) cyc((i % 2) ? 4'hF : 4'h5, 1'b0);
    check("rst_out", 32'(out_a), 32'h0);
    check("rst_hits", 32'(hits_a), 32'h0);
    w = 4'h0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc(4'h0, 1'b0);
    check("idle_out", 32'(out_a), 32'h0);

    // Single high sample: no detection.
    cyc(4'h1, 1'b0);
    check("one_high_out", 32'(out_a[0]), 32'h0);
    cyc(4'h0, 1'b0);
    check("one_high_hits", 32'(hits_a), 32'h0);

    // Level mode, four high samples: out high for three cycles.
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(4'h1, 1'b0);
      if (out_a[0]) highs++;
    end
    cyc(4'h0, 1'b0);
    if (out_a[0]) highs++;
    check("level_len", 32'(highs), 32'd3);
    check("level_hits", 32'(hits_a), 32'd1);

    // Pulse mode, same stimulus after a clear: exactly one high cycle.
    cyc(4'h0, 1'b1);
    mode = 1'b1;
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(4'h1, 1'b0);
      if (out_a[0]) highs++;
      if (i == 1) check("pulse_hits", 32'(hits_a), 32'd1);
    end
    cyc(4'h0, 1'b0);
    if (out_a[0]) highs++;
    check("pulse_len", 32'(highs), 32'd1);

    // Mode toggled while in DET: out follows mode within the cycle.
    mode = 1'b0;
    for (int i = 0; i < 3; i++) cyc(4'h1, 1'b0);
    #2 mode = 1'b1;
    #1 check("mode_to_pulse", 32'(out_a[0]), 32'h0);
    #1 mode = 1'b0;
    #1 check("mode_to_level", 32'(out_a[0]), 32'h1);
    @(negedge clk);
    cyc(4'h0, 1'b0);

    // Simultaneous detection on all four channels.
    cyc(4'h0, 1'b1);
    cyc(4'hF, 1'b0);
    check("simul_before", 32'(hits_a), 32'd0);
    cyc(4'hF, 1'b0);
    check("simul_after", 32'(hits_a), 32'd4);
    cyc(4'h0, 1'b0);

    // Wrap: 63 bursts of 4 plus one burst of 2 reach 254, then 4 more -> 2.
    cyc(4'h0, 1'b1);
    for (int i = 0; i < 63; i++) begin
      cyc(4'hF, 1'b0);
      cyc(4'hF, 1'b0);
      cyc(4'h0, 1'b0);
    end
    cyc(4'h3, 1'b0);
    cyc(4'h3, 1'b0);
    cyc(4'h0, 1'b0);
    check("pre_wrap", 32'(hits_a), 32'd254);
    cyc(4'hF, 1'b0);
    cyc(4'hF, 1'b0);
    check("wrap", 32'(hits_a), 32'd2);
    cyc(4'h0, 1'b0);

    // Clear on the detection edge, then redetection THRESH edges later.
    cyc(4'h1, 1'b0);
    cyc(4'h1, 1'b1);
    check("clr_out", 32'(out_a[0]), 32'h0);
    check("clr_hits", 32'(hits_a), 32'd0);
    cyc(4'h1, 1'b0);
    check("redet_early", 32'(out_a[0]), 32'h0);
    cyc(4'h1, 1'b0);
    check("redet", 32'(out_a[0]), 32'h1);
    check("redet_hits", 32'(hits_a), 32'd1);
    cyc(4'h0, 1'b0);

    // Async reset between edges while channel 0 is in RUN.
    cyc(4'h1, 1'b0);
    check("b_det_before_rst", 32'(out_b), 32'h1);
    #3 reset = 1'b0;
    #1 check("async_out_b", 32'(out_b), 32'h0);
    check("async_hits_a", 32'(hits_a), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_a_wait", 32'(out_a[0]), 32'h0);
    check("post_rst_b_first", 32'(out_b), 32'h1);
    cyc(4'h1, 1'b0);
    check("post_rst_a_det", 32'(out_a[0]), 32'h1);
    cyc(4'h0, 1'b0);
    cyc(4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised multi-channel run-length detector: the next generation of the board-level "input held high" FSM. Each of CHANNELS inputs is watched by its own Moore machine. The machine flags when the input has been sampled high on THRESH consecutive clock edges. Output is selectable as a level or a one-cycle pulse, and a shared counter tallies detection events. It sits behind the switch/key inputs and the clock divider; its outputs drive LEDs or downstream control.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- THRESH, 2, consecutive high samples required for detection (≥1)
- HIT_W, 8, width of the shared detection-event counter
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low: 0 forces reset immediately; release is synchronous to clk
- mode  input  1  0 = level output, 1 = pulse output
- clear  input  1  synchronous clear of all channels and the hit counter
- w  input  CHANNELS  per-channel sampled inputs
- out  output  CHANNELS  per-channel detect outputs
- hits  output  HIT_W  detection events since reset/clear, modulo 2^HIT_W

## Operation
- Each channel runs three states:
  - IDLE: run count 0.
  - RUN: 0 < count < THRESH.
  - DET: count saturated at THRESH.
- Run counter width is $clog2(THRESH+1). It increments on each edge where w[i]=1 and saturates at THRESH. Any edge with w[i]=0 returns the count to 0 and the state to IDLE.
- Transitions:
  - IDLE→RUN on w=1 when THRESH>1.
  - IDLE→DET on w=1 when THRESH=1.
  - RUN→DET when the count reaches THRESH.
  - DET→DET while w=1.
  - Any state→IDLE on w=0.
  - RUN is unreachable when THRESH=1.
- Entry event: a channel makes a transition into DET from IDLE or RUN. Each entry event sets the channel's pulse flag for exactly the following cycle.
- Output: out[i] = (state==DET) when mode=0, and pulse flag[i] when mode=1. mode is applied combinationally, so a mode change takes effect in the same cycle.
- hits: on each edge, hits += number of channels with an entry event on that edge. The add is HIT_W wide and wraps; there is no saturation.
- clear=1 at an edge has priority over w:
  - all channels go to IDLE with count 0;
  - all pulse flags go to 0;
  - hits goes to 0;
  - entry events on that edge are discarded.
- Reset values: every channel in IDLE, every count 0, every pulse flag 0, out = 0, hits = 0.
- Reset asserted mid-run (reset=0): all state clears at once, without waiting for clk. Detection restarts from IDLE after release.

## Timing
- Latency: out[i] is high in level mode in the cycle following the THRESH-th consecutive rising edge that sampled w[i]=1. It falls in the cycle following the first edge sampling w[i]=0.
- Pulse mode: out[i] is high for exactly one cycle, the same cycle level mode would first go high. The pulse re-arms only after w[i] has been sampled 0.
- Example, THRESH=2: w high at edges 1 and 2 → out high after edge 2.
- hits updates on the same edge as the entry event. It is visible in the same cycle as the pulse.
- Simultaneous entry events on k channels add k in one edge.
- No combinational path from w to out. The only combinational path is mode → out.

## Structure
- Package run_detector_pkg:
  - state enum (IDLE, RUN, DET);
  - mode encoding constants (MODE_LEVEL=0, MODE_PULSE=1).
- Sub-module run_detector_channel:
  - one instance per channel, generated CHANNELS times;
  - parameter THRESH; ports clk, reset, clear, w;
  - outputs are the DET state, the pulse flag and the entry event.
- The top level holds the mode mux, a popcount of entry events, and the hits register.

## Test plan
- Reset: hold reset=0 with w toggling → out=0 and hits=0. Release, then w[0]=0 for 4 cycles → out stays 0.
- THRESH=2, level mode:
  - w[0]=1 for 1 cycle, then 0 → no detection, hits=0.
  - w[0]=1 for 4 cycles → out[0] high for 3 cycles (after edges 2–4, falling after the first 0-sample edge), hits=1.
- Pulse mode, same 4-cycle stimulus → out[0] high for exactly 1 cycle and hits=1. Toggle mode mid-DET → out follows mode in the same cycle.
- Simultaneous detection: CHANNELS=4, all w=1 for 2 cycles → hits goes 0→4 on one edge. Preload hits to 254 with HIT_W=8 → hits wraps to 2.
- clear asserted on the detection edge → no out, hits=0, channel back in IDLE. w held at 1 → redetects THRESH edges later.
- Async reset mid-run: reset=0 between edges while in RUN → count and out clear at once. After release, a full THRESH run is needed to detect; THRESH=1 build detects on the first high sample.
